// File: rtl/reg_file_pkg.sv
// Shared register-file types and constants used by the write-port controllers.
package reg_file_pkg;

   localparam int num_regs_c      = 32;
   localparam int reg_sel_width_c = $clog2(num_regs_c);
   localparam int data_width_c    = 32;

   typedef logic [reg_sel_width_c-1:0] reg_sel_t;
   typedef logic [data_width_c-1:0]    reg_data_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      WAIT_ACK
   } wr_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr_i.
module rr_arbiter #(
   parameter int num_req = 4,
   localparam int idx_w = (num_req > 1) ? $clog2(num_req) : 1
) (
   input  logic [num_req-1:0] eligible_i,
   input  logic [idx_w-1:0]   ptr_i,
   output logic [num_req-1:0] grant_o,
   output logic [idx_w-1:0]   idx_o,
   output logic               valid_o
);

   always_comb begin
      int j;
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      j       = 0;
      for (int k = 0; k < num_req; k++) begin
         j = (int'(ptr_i) + k) % num_req;
         if (!valid_o && eligible_i[j]) begin
            valid_o    = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = idx_w'(j);
         end
      end
   end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Shares the register file's secondary write port between result producers,
// one req/ack write at a time, and tracks in-flight destinations in busy_mask.
module reg_file_wr_arbiter
   import reg_file_pkg::*;
#(
   parameter int num_req       = 4,
   parameter int num_regs      = num_regs_c,
   parameter int reg_sel_width = reg_sel_width_c,
   parameter int data_width    = data_width_c,
   parameter int ack_timeout   = 15
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [num_req-1:0]               req_valid,
   input  logic [num_req*reg_sel_width-1:0] req_sel,
   input  logic [num_req*data_width-1:0]    req_data,
   output logic [num_req-1:0]               req_done,
   input  logic                             issue_valid,
   input  logic [reg_sel_width-1:0]         issue_sel,
   input  logic                             proc_wr_req,
   input  logic [reg_sel_width-1:0]         proc_rd_sel,
   output logic                             wr_req,
   output logic [reg_sel_width-1:0]         wr_sel,
   output logic [data_width-1:0]            wr_data,
   input  logic                             wr_ack,
   output logic [num_regs-1:0]              busy_mask,
   output logic                             timeout_err
);

   localparam int ptr_w    = (num_req > 1) ? $clog2(num_req) : 1;
   localparam int tmo_w    = $clog2(ack_timeout + 1);
   localparam bit ptr_pow2 = (num_req & (num_req - 1)) == 0;

   wr_arb_state_e            state_q;
   logic [ptr_w-1:0]         rr_ptr_q;
   logic [ptr_w-1:0]         win_q;
   logic [tmo_w-1:0]         tmo_cnt_q;
   logic                     wr_req_q;
   logic                     timeout_err_q;
   logic [reg_sel_width-1:0] wr_sel_q;
   logic [data_width-1:0]    wr_data_q;
   logic [num_req-1:0]       req_done_q;
   logic [num_regs-1:0]      busy_q;
   logic [num_regs-1:0]      busy_d;

   logic [reg_sel_width-1:0] sel_arr  [num_req];
   logic [data_width-1:0]    data_arr [num_req];
   logic [num_req-1:0]       eligible;
   logic [num_req-1:0]       grant;
   logic [ptr_w-1:0]         win_idx;
   logic                     grant_valid;
   logic                     tmo_hit;
   logic                     wr_finish;

   // A producer whose done pulse is showing still holds req_valid this cycle,
   // so it is masked to avoid writing the same result twice.
   for (genvar g = 0; g < num_req; g++) begin : g_req
      assign sel_arr[g]  = req_sel[g*reg_sel_width +: reg_sel_width];
      assign data_arr[g] = req_data[g*data_width +: data_width];
      assign eligible[g] = req_valid[g] && !req_done_q[g] &&
                           !(proc_wr_req && (sel_arr[g] == proc_rd_sel));
   end

   rr_arbiter #(
      .num_req (num_req)
   ) u_rr_arbiter (
      .eligible_i (eligible),
      .ptr_i      (rr_ptr_q),
      .grant_o    (grant),
      .idx_o      (win_idx),
      .valid_o    (grant_valid)
   );

   function automatic logic [ptr_w-1:0] next_ptr(input logic [ptr_w-1:0] idx);
      if (ptr_pow2) return idx + 1'b1;
      return (idx == ptr_w'(num_req - 1)) ? '0 : idx + 1'b1;
   endfunction

   // Counter reaches ack_timeout on the edge where it already holds ack_timeout-1.
   assign tmo_hit   = (tmo_cnt_q == tmo_w'(ack_timeout - 1));
   assign wr_finish = (state_q == WAIT_ACK) && (wr_ack || tmo_hit);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         win_q         <= '0;
         tmo_cnt_q     <= '0;
         wr_req_q      <= 1'b0;
         wr_sel_q      <= '0;
         wr_data_q     <= '0;
         req_done_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         req_done_q <= '0;
         wr_req_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  win_q <= win_idx;
                  if (sel_arr[win_idx] == '0) begin
                     req_done_q <= grant;
                     rr_ptr_q   <= next_ptr(win_idx);
                  end else begin
                     wr_sel_q  <= sel_arr[win_idx];
                     wr_data_q <= data_arr[win_idx];
                     wr_req_q  <= 1'b1;
                     state_q   <= WRITE;
                  end
               end
            end
            WRITE: begin
               tmo_cnt_q <= '0;
               state_q   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (wr_ack || tmo_hit) begin
                  req_done_q[win_q] <= 1'b1;
                  rr_ptr_q          <= next_ptr(win_q);
                  state_q           <= IDLE;
                  if (!wr_ack) timeout_err_q <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A new issue to the same register outranks the retiring write's clear.
   always_comb begin
      busy_d = busy_q;
      if (wr_finish) busy_d[wr_sel_q] = 1'b0;
      if (issue_valid && (issue_sel != '0)) busy_d[issue_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) busy_q <= '0;
      else      busy_q <= busy_d;
   end

   assign wr_req      = wr_req_q;
   assign wr_sel      = wr_sel_q;
   assign wr_data     = wr_data_q;
   assign req_done    = req_done_q;
   assign busy_mask   = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed bench for reg_file_wr_arbiter; expected values are hand-derived.
module tb_reg_file_wr_arbiter;

   localparam int NR = 4;
   localparam int SW = 5;
   localparam int DW = 32;
   localparam int NG = 32;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR*SW-1:0]  req_sel;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_done;
   logic              issue_valid;
   logic [SW-1:0]     issue_sel;
   logic              proc_wr_req;
   logic [SW-1:0]     proc_rd_sel;
   logic              wr_req;
   logic [SW-1:0]     wr_sel;
   logic [DW-1:0]     wr_data;
   logic              wr_ack;
   logic [NG-1:0]     busy_mask;
   logic              timeout_err;

   int checks;
   int failures;
   logic ack_en;

   reg_file_wr_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_sel     (req_sel),
      .req_data    (req_data),
      .req_done    (req_done),
      .issue_valid (issue_valid),
      .issue_sel   (issue_sel),
      .proc_wr_req (proc_wr_req),
      .proc_rd_sel (proc_rd_sel),
      .wr_req      (wr_req),
      .wr_sel      (wr_sel),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .busy_mask   (busy_mask),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; the register-file ack model answers a wr_req one cycle later.
   task automatic tick();
      logic prev;
      prev = (wr_req === 1'b1);
      @(posedge clk);
      #1;
      wr_ack = ack_en && prev;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d);
      req_valid[i]          = v;
      req_sel[i*SW +: SW]   = s;
      req_data[i*DW +: DW]  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int order [5];
      int p;
      checks      = 0;
      failures    = 0;
      ack_en      = 1'b1;
      rst         = 1'b0;
      req_valid   = '0;
      req_sel     = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_sel   = '0;
      proc_wr_req = 1'b0;
      proc_rd_sel = '0;
      wr_ack      = 1'b0;

      // Reset state
      tick();
      chk("rst_wr_req", 64'(wr_req), 64'd0);
      chk("rst_wr_sel", 64'(wr_sel), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_req_done", 64'(req_done), 64'd0);
      chk("rst_busy", 64'(busy_mask), 64'd0);
      chk("rst_tmo", 64'(timeout_err), 64'd0);
      rst = 1'b1;

      // Single producer 1, sel 5
      set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      chk("t1_wr_req", 64'(wr_req), 64'd1);
      chk("t1_wr_sel", 64'(wr_sel), 64'd5);
      chk("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
      tick();
      chk("t1_wr_req_one_cycle", 64'(wr_req), 64'd0);
      chk("t1_done_early", 64'(req_done), 64'd0);
      tick();
      chk("t1_done", 64'(req_done), 64'b0010);
      set_req(1, 1'b0, 5'd0, 32'd0);
      tick();
      chk("t1_done_single", 64'(req_done), 64'd0);
      chk("t1_no_rewrite_a", 64'(wr_req), 64'd0);
      tick();
      chk("t1_no_rewrite_b", 64'(wr_req), 64'd0);

      // Round robin from reset: 0,1,2,3 then 0 again (producer 0 re-requests)
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, SW'(i + 1), 32'hA0 + 32'(i));
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
      for (int r = 0; r < 5; r++) begin
         p = order[r];
         tick();
         chk($sformatf("rr%0d_wr_req", r), 64'(wr_req), 64'd1);
         chk($sformatf("rr%0d_wr_sel", r), 64'(wr_sel), 64'(p + 1));
         chk($sformatf("rr%0d_wr_data", r), 64'(wr_data), 64'(32'hA0 + 32'(p)));
         tick();
         chk($sformatf("rr%0d_wait", r), 64'(wr_req), 64'd0);
         tick();
         chk($sformatf("rr%0d_done", r), 64'(req_done), 64'(1 << p));
         if (p != 0 || r == 4) set_req(p, 1'b0, 5'd0, 32'd0);
      end

      // Collision: producer 0 (sel 7) deferred while processor writes r7
      rst = 1'b0;
      tick();
      rst = 1'b1;
      set_req(0, 1'b1, 5'd7, 32'h70);
      set_req(2, 1'b1, 5'd3, 32'h30);
      proc_wr_req = 1'b1;
      proc_rd_sel = 5'd7;
      tick();
      chk("col_grant_p2", 64'(wr_sel), 64'd3);
      chk("col_wr_req", 64'(wr_req), 64'd1);
      tick();
      chk("col_p0_held", 64'(req_done), 64'd0);
      proc_wr_req = 1'b0;
      tick();
      chk("col_done_p2", 64'(req_done), 64'b0100);
      set_req(2, 1'b0, 5'd0, 32'd0);
      tick();
      chk("col_grant_p0", 64'(wr_sel), 64'd7);
      chk("col_p0_wr_req", 64'(wr_req), 64'd1);
      tick();
      tick();
      chk("col_done_p0", 64'(req_done), 64'b0001);
      set_req(0, 1'b0, 5'd0, 32'd0);

      // Scoreboard set by issue, cleared after the ack for that register
      issue_valid = 1'b1;
      issue_sel   = 5'd9;
      tick();
      chk("sb_set9", 64'(busy_mask), 64'h200);
      issue_valid = 1'b0;
      set_req(1, 1'b1, 5'd9, 32'h99);
      tick();
      chk("sb_wr_sel9", 64'(wr_sel), 64'd9);
      chk("sb_busy_in_write", 64'(busy_mask), 64'h200);
      tick();
      chk("sb_busy_in_wait", 64'(busy_mask), 64'h200);
      tick();
      chk("sb_done", 64'(req_done), 64'b0010);
      chk("sb_cleared", 64'(busy_mask), 64'd0);
      set_req(1, 1'b0, 5'd0, 32'd0);
      tick();

      // Issue to r9 in the same cycle as the ack for r9: set wins
      issue_valid = 1'b1;
      issue_sel   = 5'd9;
      set_req(1, 1'b1, 5'd9, 32'h98);
      tick();
      chk("sb2_wr_req", 64'(wr_req), 64'd1);
      issue_valid = 1'b0;
      tick();
      issue_valid = 1'b1;
      tick();
      chk("sb2_done", 64'(req_done), 64'b0010);
      chk("sb2_set_wins", 64'(busy_mask), 64'h200);
      issue_valid = 1'b0;
      set_req(1, 1'b0, 5'd0, 32'd0);

      // Reset clears the scoreboard; issue to r0 never marks busy
      rst = 1'b0;
      tick();
      chk("rst2_busy", 64'(busy_mask), 64'd0);
      rst = 1'b1;
      issue_valid = 1'b1;
      issue_sel   = 5'd0;
      tick();
      chk("sb_sel0", 64'(busy_mask), 64'd0);
      issue_valid = 1'b0;

      // Select-0 result retires without touching the port
      set_req(3, 1'b1, 5'd0, 32'h33);
      tick();
      chk("sel0_done", 64'(req_done), 64'b1000);
      chk("sel0_no_wr", 64'(wr_req), 64'd0);
      set_req(3, 1'b0, 5'd0, 32'd0);
      tick();
      chk("sel0_done_once", 64'(req_done), 64'd0);
      chk("sel0_no_wr_b", 64'(wr_req), 64'd0);

      // Ack withheld: 15 cycles in WAIT_ACK, then timeout
      ack_en      = 1'b0;
      issue_valid = 1'b1;
      issue_sel   = 5'd12;
      set_req(2, 1'b1, 5'd12, 32'hC0C0);
      tick();
      chk("to_wr_req", 64'(wr_req), 64'd1);
      chk("to_busy", 64'(busy_mask), 64'h1000);
      issue_valid = 1'b0;
      for (int k = 0; k < 15; k++) tick();
      chk("to_not_yet_err", 64'(timeout_err), 64'd0);
      chk("to_not_yet_done", 64'(req_done), 64'd0);
      tick();
      chk("to_err", 64'(timeout_err), 64'd1);
      chk("to_done", 64'(req_done), 64'b0100);
      chk("to_busy_clr", 64'(busy_mask), 64'd0);
      set_req(2, 1'b0, 5'd0, 32'd0);
      tick();
      chk("to_sticky", 64'(timeout_err), 64'd1);
      chk("to_idle", 64'(wr_req), 64'd0);

      // Reset in the middle of a write; a late ack is then ignored
      issue_valid = 1'b1;
      issue_sel   = 5'd12;
      set_req(2, 1'b1, 5'd12, 32'hC1C1);
      tick();
      chk("mid_wr_req", 64'(wr_req), 64'd1);
      issue_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rst_err", 64'(timeout_err), 64'd0);
      chk("mid_rst_busy", 64'(busy_mask), 64'd0);
      chk("mid_rst_done", 64'(req_done), 64'd0);
      rst = 1'b1;
      set_req(2, 1'b0, 5'd0, 32'd0);
      wr_ack = 1'b1;
      tick();
      chk("late_ack_done", 64'(req_done), 64'd0);
      chk("late_ack_wr", 64'(wr_req), 64'd0);
      tick();
      chk("late_ack_done_b", 64'(req_done), 64'd0);
      chk("late_ack_err", 64'(timeout_err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_wr_arbiter.md
Name: reg_file_wr_arbiter

Overview:
- Shares the register file's single secondary (APU-side) write port between num_req long-latency result producers, e.g. APU, load unit and divider.
- Round-robin arbitration; each write is sequenced through the port's req/ack handshake.
- Keeps a pending-write scoreboard so the processor can stall reads of in-flight registers.
- Sits between the producers and the register file's apu_wr_req/apu_ack/apu_wr_sel/apu_wr_data.

Parameters:
- num_req, 4, number of result producers
- num_regs, 32, register count
- reg_sel_width, 5, register select width, equal to $clog2(num_regs)
- data_width, 32, register data width
- ack_timeout, 15, cycles allowed in WAIT_ACK before the error flag sets

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- req_valid  input  num_req  producer i has a result
- req_sel  input  num_req*reg_sel_width  destination of producer i, slice i
- req_data  input  num_req*data_width  result of producer i, slice i
- req_done  output  num_req  one-cycle pulse: producer i's result has been consumed
- issue_valid  input  1  processor dispatched a long-latency op
- issue_sel  input  reg_sel_width  destination of that op
- proc_wr_req  input  1  processor write-port request, snooped
- proc_rd_sel  input  reg_sel_width  processor write destination, snooped
- wr_req  output  1  to register file apu_wr_req
- wr_sel  output  reg_sel_width  to apu_wr_sel
- wr_data  output  data_width  to apu_wr_data
- wr_ack  input  1  from apu_ack, registered in the register file (arrives the cycle after wr_req)
- busy_mask  output  num_regs  bit r set: a write to r is pending
- timeout_err  output  1  sticky: ack never arrived

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, wr_req=0, wr_sel=0, wr_data=0, req_done=0, busy_mask=0, timeout_err=0, rr pointer=0, timeout counter=0. Reset mid-write abandons the write; a late wr_ack arriving in IDLE is ignored.
- FSM states: IDLE, WRITE, WAIT_ACK.
- IDLE:
  - Eligible requester: req_valid[i]=1 and NOT (proc_wr_req=1 and req_sel[i]==proc_rd_sel). Same-cycle same-register collisions are deferred.
  - Winner = first eligible at or after the rr pointer, wrapping modulo num_req.
  - If the winner's sel==0: pulse req_done[winner] next cycle, issue no write, advance rr, stay IDLE.
  - Otherwise latch sel and data into wr_sel/wr_data and go to WRITE.
- WRITE: wr_req=1 for exactly one cycle, then go to WAIT_ACK. wr_req is never held for two cycles, because that would double-write.
- WAIT_ACK:
  - wr_req=0.
  - On wr_ack=1: pulse req_done[winner] for one cycle; clear busy_mask[wr_sel]; rr pointer = winner+1 mod num_req; go to IDLE.
  - The timeout counter increments each cycle without an ack. On reaching ack_timeout: set timeout_err (sticky until reset), pulse req_done, clear the busy bit, go to IDLE.
- Producers hold req_valid/sel/data stable until req_done. The arbiter samples them only in IDLE.
- Latency: uncontended grant to req_done is 3 cycles (IDLE decide, WRITE, WAIT_ACK with ack). Peak throughput is 1 write per 3 cycles.
- Scoreboard:
  - issue_valid sets busy_mask[issue_sel] at the next edge. Select 0 is never set.
  - Set and clear of the same bit in the same cycle: set wins, because a new op is in flight.
  - busy_mask is a registered output.
- Widths: rr pointer is $clog2(num_req) bits and wraps without an explicit compare when num_req is a power of two; otherwise it wraps by compare. Timeout counter is $clog2(ack_timeout+1) bits.

Decomposition:
- Shared package reg_file_pkg:
  - num_regs, reg_sel_width, data_width constants
  - reg_sel_t and reg_data_t typedefs
  - arbiter state enum wr_arb_state_e {IDLE, WRITE, WAIT_ACK}
- Sub-module rr_arbiter (num_req):
  - inputs: eligible mask, rr pointer
  - outputs: one-hot grant and index
  - combinational; reusable by other shared-port controllers.

Test Plan:
- Single producer 1, sel=5, data=0xDEADBEEF:
  - wr_req high exactly one cycle with wr_sel=5 and wr_data=0xDEADBEEF
  - req_done[1] 2 cycles later
  - no second wr_req
- All 4 producers valid from reset, distinct sels 1..4: grants in order 0,1,2,3, then 0 again on re-request. No producer is granted twice before the others are served.
- Collision: producer 0 sel=7 while proc_wr_req=1 and proc_rd_sel=7 for 2 cycles:
  - producer 0 is not granted during those cycles
  - producer 2 (sel=3) is granted instead
  - producer 0 is granted once proc_wr_req drops.
- Scoreboard:
  - issue_valid sel=9 -> busy_mask[9]=1 next cycle, cleared the cycle after wr_ack for sel=9.
  - issue_valid sel=9 in the same cycle as that ack -> busy_mask[9] stays 1.
  - issue_sel=0 -> busy_mask stays 0.
- Sel 0 write: req_done pulses, wr_req never asserts.
- Withhold wr_ack:
  - after ack_timeout cycles timeout_err=1, req_done pulses, FSM returns to IDLE
  - rst=0 for one cycle clears timeout_err and busy_mask
  - a late wr_ack after reset produces no req_done.
